priority_encoder_8to3_seq: RTL

Sequential 8-to-3 encoder: the encode-side counterpart of the 3-to-8 decoder. It accepts an 8-bit request vector over a valid/ready handshake and emits one 3-bit binary code per set bit, in priority order, over a second valid/ready handshake. Each beat carries a beat index and a last flag, so a downstream 3-to-8 decoder can rebuild the vector one line at a time. It sits between request sources (interrupt lines, one-hot selects) and logic that consumes binary indices.

---
 rtl/priority_encoder_8to3_seq_if.sv | 23 ++
 rtl/priority_encoder_8to3_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/priority_encoder_8to3_seq_if.sv
// Request/beat handshake bundle for the sequential 8-to-3 encoder.
// The master side (source/consumer) drives in_* and out_ready; the slave side is the encoder.
interface priority_encoder_8to3_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic [2:0] out_beat;
  logic       out_last;
  logic       out_none;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_code, out_beat, out_last, out_none
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_code, out_beat, out_last, out_none
  );
endinterface

// File: rtl/priority_encoder_8to3_seq.sv
// Sequential 8-to-3 encoder: takes an 8-bit request vector and streams one
// binary code per set bit in priority order, with beat index and last flag.
module priority_encoder_8to3_seq #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  priority_encoder_8to3_seq_if.slave   bus
);

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pend,  w_pend_nxt;
  logic [2:0] r_beat,  w_beat_nxt;
  logic       r_none,  w_none_nxt;

  logic [2:0] w_code;
  logic [3:0] w_cnt;
  logic       w_last;
  logic       w_valid;
  logic       w_xfer;
  logic       w_in_ready;
  logic       w_accept;

  // Later loop iterations win, so the scan direction sets the priority.
  always_comb begin
    w_code = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (r_pend[i]) w_code = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (r_pend[i]) w_code = 3'(i);
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 8; i++) w_cnt = w_cnt + {3'b000, r_pend[i]};
  end

  // A zero vector has popcount 0, so it naturally reads as a single last beat.
  assign w_last     = (w_cnt <= 4'd1);
  assign w_valid    = (r_state == S_EMIT);
  assign w_xfer     = w_valid && bus.out_ready;
  assign w_in_ready = !w_valid || (w_xfer && w_last);
  assign w_accept   = bus.in_valid && w_in_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_EMIT;
      S_EMIT: if (w_xfer && w_last) w_state_nxt = w_accept ? S_EMIT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs, forced to zero outside EMIT
  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = 1'b0;
    bus.out_code  = '0;
    bus.out_beat  = '0;
    bus.out_last  = 1'b0;
    bus.out_none  = 1'b0;
    if (w_valid) begin
      bus.out_valid = 1'b1;
      bus.out_code  = w_code;
      bus.out_beat  = r_beat;
      bus.out_last  = w_last;
      bus.out_none  = r_none;
    end
  end

  // Pending mask / beat counter. A finished vector clears to zero so beat never wraps.
  always_comb begin
    w_pend_nxt = r_pend;
    w_beat_nxt = r_beat;
    w_none_nxt = r_none;
    if (w_accept) begin
      w_pend_nxt = bus.in_vec;
      w_beat_nxt = '0;
      w_none_nxt = (bus.in_vec == 8'h00);
    end else if (w_xfer) begin
      if (w_last) begin
        w_pend_nxt = '0;
        w_beat_nxt = '0;
        w_none_nxt = 1'b0;
      end else begin
        w_pend_nxt = r_pend & ~(8'h01 << w_code);
        w_beat_nxt = r_beat + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_beat <= '0;
      r_none <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_beat <= w_beat_nxt;
      r_none <= w_none_nxt;
    end
  end

endmodule
